// File: rtl/display_pkg.sv
// Shared view encodings and widths for the hex-display sequencer.
package display_pkg;

    typedef enum logic [2:0] {
        VIEW_PC_LO  = 3'd0,
        VIEW_PC_HI  = 3'd1,
        VIEW_REG_LO = 3'd2,
        VIEW_REG_HI = 3'd3,
        VIEW_INS_LO = 3'd4,
        VIEW_INS_HI = 3'd5
    } view_t;

    localparam view_t       VIEW_LAST  = VIEW_INS_HI;
    localparam int unsigned REG_ADDR_W = 5;

    // Cyclic successor; never produces the unused encodings 6 and 7.
    function automatic view_t next_view(input view_t v);
        return (v == VIEW_LAST) ? VIEW_PC_LO : view_t'(v + 3'd1);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stability counter, and a
// one-cycle press pulse on each accepted rising level.
module btn_debounce
    import display_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic press
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);

    logic             sync_1;
    logic             sync_2;
    logic             level;
    logic             level_d;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_1  <= 1'b0;
            sync_2  <= 1'b0;
            level   <= 1'b0;
            level_d <= 1'b0;
            cnt     <= '0;
        end else begin
            sync_1  <= raw;
            sync_2  <= sync_1;
            level_d <= level;
            // Any cycle of agreement restarts the stability window.
            if (sync_2 != level) begin
                if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    level <= sync_2;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

    assign press = level & ~level_d;

endmodule

// File: rtl/display_controller.sv
// View/register-address sequencer for the four-digit hex display: debounced
// single-step buttons plus an optional timed auto-scroll.
module display_controller
    import display_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned DWELL_CYCLES    = 50000000,
    parameter int unsigned NUM_REGS        = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_next,
    input  logic       btn_reg,
    input  logic       sw_auto,
    output logic [2:0] sel,
    output logic [4:0] reg_addr,
    output logic       auto_active,
    output logic       view_changed
);

    localparam int unsigned DWELL_W = $clog2(DWELL_CYCLES);

    logic                  next_press;
    logic                  reg_press;
    logic                  auto_s1;
    logic [DWELL_W-1:0]    dwell_q;
    logic [DWELL_W-1:0]    dwell_d;
    view_t                 view_q;
    view_t                 view_d;
    logic [REG_ADDR_W-1:0] reg_q;
    logic [REG_ADDR_W-1:0] reg_d;
    logic                  changed_d;
    logic                  expiry;
    logic                  advance;
    logic                  reg_step;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next_db (
        .clk   (clk),
        .rst   (rst),
        .raw   (btn_next),
        .press (next_press)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_reg_db (
        .clk   (clk),
        .rst   (rst),
        .raw   (btn_reg),
        .press (reg_press)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            auto_s1      <= 1'b0;
            auto_active  <= 1'b0;
            dwell_q      <= '0;
            view_q       <= VIEW_PC_LO;
            reg_q        <= '0;
            view_changed <= 1'b0;
        end else begin
            auto_s1      <= sw_auto;
            auto_active  <= auto_s1;
            dwell_q      <= dwell_d;
            view_q       <= view_d;
            reg_q        <= reg_d;
            view_changed <= changed_d;
        end
    end

    always_comb begin
        expiry    = auto_active && (dwell_q == DWELL_W'(DWELL_CYCLES - 1));
        advance   = next_press || expiry;
        // Register stepping is gated by the view shown before this cycle's advance.
        reg_step  = reg_press && (view_q == VIEW_REG_LO || view_q == VIEW_REG_HI);
        view_d    = view_q;
        reg_d     = reg_q;
        dwell_d   = '0;
        changed_d = advance || reg_step;
        if (advance) begin
            view_d = next_view(view_q);
        end
        if (reg_step) begin
            reg_d = (reg_q == REG_ADDR_W'(NUM_REGS - 1)) ? '0 : reg_q + 1'b1;
        end
        if (auto_active && !advance) begin
            dwell_d = dwell_q + 1'b1;
        end
    end

    assign sel      = view_q;
    assign reg_addr = reg_q;

endmodule

// File: tb/tb_display_controller.sv
// Randomized and directed checks of display_controller against a behavioural model.
module tb_display_controller;

    localparam int DB = 4;
    localparam int DW = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_next = 1'b0;
    logic       btn_reg = 1'b0;
    logic       sw_auto = 1'b0;
    logic [2:0] sel;
    logic [4:0] reg_addr;
    logic       auto_active;
    logic       view_changed;

    display_controller #(
        .DEBOUNCE_CYCLES (DB),
        .DWELL_CYCLES    (DW),
        .NUM_REGS        (32)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_next     (btn_next),
        .btn_reg      (btn_reg),
        .sw_auto      (sw_auto),
        .sel          (sel),
        .reg_addr     (reg_addr),
        .auto_active  (auto_active),
        .view_changed (view_changed)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    bit chk_en = 1'b0;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference model: views advance on accepted presses or dwell expiry; a button
    // level is accepted once its synchronized copy has disagreed for DB edges in a row.
    int m_sel = 0, m_reg = 0, m_dwell = 0;
    bit m_vc = 0, m_auto = 0, m_as1 = 0, m_adv = 0, m_rinc = 0;
    bit b_s1[2], b_s2[2], b_lvl[2], b_pend[2], raw_v[2];
    int b_streak[2];

    always @(posedge clk) begin
        cyc++;
        raw_v[0] = btn_next;
        raw_v[1] = btn_reg;
        if (rst) begin
            m_sel = 0; m_reg = 0; m_dwell = 0; m_vc = 0; m_auto = 0; m_as1 = 0;
            for (int b = 0; b < 2; b++) begin
                b_s1[b] = 0; b_s2[b] = 0; b_lvl[b] = 0; b_pend[b] = 0; b_streak[b] = 0;
            end
        end else begin
            m_adv  = b_pend[0] || (m_auto && m_dwell == DW - 1);
            m_rinc = b_pend[1] && (m_sel == 2 || m_sel == 3);
            m_vc   = m_adv || m_rinc;
            if (m_adv)  m_sel = (m_sel + 1) % 6;
            if (m_rinc) m_reg = (m_reg + 1) % 32;
            m_dwell = (m_auto && !m_adv) ? m_dwell + 1 : 0;
            m_auto  = m_as1;
            m_as1   = sw_auto;
            for (int b = 0; b < 2; b++) begin
                b_pend[b]   = 0;
                b_streak[b] = (b_s2[b] != b_lvl[b]) ? b_streak[b] + 1 : 0;
                if (b_streak[b] == DB) begin
                    b_lvl[b]    = b_s2[b];
                    b_streak[b] = 0;
                    b_pend[b]   = b_lvl[b];
                end
                b_s2[b] = b_s1[b];
                b_s1[b] = raw_v[b];
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check_eq("sel", sel, m_sel);
            check_eq("reg_addr", reg_addr, m_reg);
            check_eq("auto_active", auto_active, m_auto);
            check_eq("view_changed", view_changed, m_vc);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input bit which, input int hold, input int gap);
        if (which) btn_reg = 1'b1; else btn_next = 1'b1;
        tick(hold);
        if (which) btn_reg = 1'b0; else btn_next = 1'b0;
        tick(gap);
    endtask

    task automatic goto_view(input int target);
        for (int i = 0; i < 6 && m_sel != target; i++) press(1'b0, 6, 6);
    endtask

    task automatic wait_vc(input string tag, input int budget, output int at);
        int i;
        at = -1;
        for (i = 0; i < budget; i++) begin
            @(negedge clk);
            if (view_changed) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) check_eq({tag, "_timeout"}, 0, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t_rise, t1, t2, s0;

        tick(2);
        chk_en = 1'b1;
        rst = 1'b0;

        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check_eq("idle_vc", view_changed, 0);
        end
        tick(1);
        check_eq("idle_sel", sel, 0);
        check_eq("idle_reg", reg_addr, 0);

        // Clean press held 20 sampled edges: sel changes exactly at E6.
        btn_next = 1'b1;
        @(posedge clk);
        for (int i = 0; i <= 7; i++) begin
            @(negedge clk);
            check_eq("press_sel", sel, (i >= 6) ? 1 : 0);
            check_eq("press_vc", view_changed, (i == 6) ? 1 : 0);
        end
        tick(12);
        btn_next = 1'b0;
        tick(10);
        check_eq("hold_no_repeat", sel, 1);
        repeat (5) press(1'b0, 8, 8);
        check_eq("wrap_sel", sel, 0);

        // Bounce rejection, then the minimum accepted width.
        press(1'b0, 3, 12);
        check_eq("glitch3_sel", sel, 0);
        press(1'b0, 4, 12);
        check_eq("pulse4_sel", sel, 1);

        goto_view(0);
        press(1'b1, 6, 6);
        check_eq("reg_gated", reg_addr, 0);
        goto_view(2);
        repeat (33) press(1'b1, 6, 6);
        check_eq("reg_wrap", reg_addr, 1);

        // Auto-scroll spacing.
        sw_auto = 1'b1;
        t_rise = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (auto_active) begin
                t_rise = cyc;
                break;
            end
        end
        if (t_rise < 0) check_eq("auto_rise_timeout", 0, 1);
        wait_vc("auto1", 30, t1);
        check_eq("auto_first_gap", t1 - t_rise, DW);
        wait_vc("auto2", 30, t2);
        check_eq("auto_gap", t2 - t1, DW);

        // Press whose pulse coincides with an expiry: one step only.
        s0 = m_sel;
        tick(3);
        btn_next = 1'b1;
        for (int i = 0; i < 30 && cyc < t2 + DW; i++) @(negedge clk);
        check_eq("coincide_sel", sel, (s0 + 1) % 6);
        check_eq("coincide_vc", view_changed, 1);
        wait_vc("after_coincide", 30, t1);
        check_eq("coincide_gap", t1 - (t2 + DW), DW);
        tick(1);
        btn_next = 1'b0;
        sw_auto = 1'b0;
        tick(12);

        // Reset mid-operation.
        goto_view(2);
        for (int i = 0; i < 32 && m_reg != 7; i++) press(1'b1, 6, 6);
        goto_view(4);
        check_eq("pre_rst_sel", sel, 4);
        check_eq("pre_rst_reg", reg_addr, 7);
        sw_auto = 1'b1;
        tick(3);
        btn_next = 1'b1;
        tick(3);
        rst = 1'b1;
        tick(1);
        check_eq("rst_sel", sel, 0);
        check_eq("rst_reg", reg_addr, 0);
        check_eq("rst_auto", auto_active, 0);
        check_eq("rst_vc", view_changed, 0);
        rst = 1'b0;
        btn_next = 1'b0;
        tick(8);
        check_eq("rst_drop_press", sel, 0);

        sw_auto = 1'b0;
        btn_next = 1'b1;
        tick(2);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(8);
        check_eq("rst_held_press", sel, 1);
        btn_next = 1'b0;
        tick(10);

        // Randomized stretch, checked cycle by cycle against the model.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(5, 0) == 0) btn_next = ~btn_next;
            if ($urandom_range(5, 0) == 0) btn_reg  = ~btn_reg;
            if ($urandom_range(59, 0) == 0) sw_auto = ~sw_auto;
            rst = ($urandom_range(299, 0) == 0);
            tick(1);
        end
        rst = 1'b0;
        tick(5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
